// File: rtl/unit1_issue_fifo_pkg.sv
// Shared core definitions: opcode constants, instruction/operand field layouts
// and the result-bus wakeup helper used by the issue queue entries.
package unit1_issue_fifo_pkg;

  localparam int PC_W    = 14;
  localparam int OPE_W   = 6;
  localparam int DD_W    = 6;
  localparam int IMM_W   = 16;
  localparam int OPR_W   = 5;
  localparam int CTRL_W  = 4;
  localparam int VAL_W   = 32;
  localparam int TAG_W   = 6;
  localparam int COUNT_W = 4;

  localparam logic [OPE_W-1:0] OPE_NOP = 6'b000000;
  localparam logic [OPE_W-1:0] OPE_ADD = 6'b001100;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [OPE_W-1:0]  ope;
    logic [DD_W-1:0]   dd;
    logic [IMM_W-1:0]  imm;
    logic [OPR_W-1:0]  opr;
    logic [CTRL_W-1:0] ctrl;
  } instr_t;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [VAL_W-1:0]  val;
  } opnd_t;

  // A waiting operand captures the first matching result bus; wb0 has priority.
  function automatic opnd_t wake_opnd(
    input opnd_t             cur,
    input logic [TAG_W-1:0]  wb0_addr,
    input logic [VAL_W-1:0]  wb0_val,
    input logic [TAG_W-1:0]  wb1_addr,
    input logic [VAL_W-1:0]  wb1_val
  );
    opnd_t res;
    res = cur;
    if (cur.rdy) begin
      res = cur;
    end else if ((wb0_addr != {TAG_W{1'b0}}) && (wb0_addr == cur.tag)) begin
      res.rdy = 1'b1;
      res.val = wb0_val;
    end else if ((wb1_addr != {TAG_W{1'b0}}) && (wb1_addr == cur.tag)) begin
      res.rdy = 1'b1;
      res.val = wb1_val;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/unit1_iq_entry.sv
// One issue-queue slot: instruction fields plus two operands that wake up
// from the result buses while waiting, including on the enqueue edge.
module unit1_iq_entry
  import unit1_issue_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             pop,
  input  instr_t           enq_instr,
  input  opnd_t            enq_ds,
  input  opnd_t            enq_dt,
  input  logic [TAG_W-1:0] wb0_addr,
  input  logic [VAL_W-1:0] wb0_val,
  input  logic [TAG_W-1:0] wb1_addr,
  input  logic [VAL_W-1:0] wb1_val,
  output logic             valid,
  output instr_t           instr,
  output logic             ds_rdy,
  output logic [VAL_W-1:0] ds_val,
  output logic             dt_rdy,
  output logic [VAL_W-1:0] dt_val
);

  logic   valid_r;
  instr_t instr_r;
  opnd_t  ds_r;
  opnd_t  dt_r;

  // Slot state: clear, fill, release or wake waiting operands.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_r <= 1'b0;
      instr_r <= '0;
      ds_r    <= '0;
      dt_r    <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      instr_r <= enq_instr;
      ds_r    <= wake_opnd(enq_ds, wb0_addr, wb0_val, wb1_addr, wb1_val);
      dt_r    <= wake_opnd(enq_dt, wb0_addr, wb0_val, wb1_addr, wb1_val);
    end else if (pop) begin
      valid_r <= 1'b0;
    end else if (valid_r) begin
      ds_r    <= wake_opnd(ds_r, wb0_addr, wb0_val, wb1_addr, wb1_val);
      dt_r    <= wake_opnd(dt_r, wb0_addr, wb0_val, wb1_addr, wb1_val);
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid  = valid_r;
  assign instr  = instr_r;
  assign ds_rdy = ds_r.rdy;
  assign ds_val = ds_r.val;
  assign dt_rdy = dt_r.rdy;
  assign dt_val = dt_r.val;

endmodule

// File: rtl/unit1_issue_fifo.sv
// In-order issue queue between decode and execute: circular buffer of
// unit1_iq_entry slots, head-only issue into a registered issue slot.
module unit1_issue_fifo
  import unit1_issue_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [PC_W-1:0]    enq_pc,
  input  logic [OPE_W-1:0]   enq_ope,
  input  logic [DD_W-1:0]    enq_dd,
  input  logic [IMM_W-1:0]   enq_imm,
  input  logic [OPR_W-1:0]   enq_opr,
  input  logic [CTRL_W-1:0]  enq_ctrl,
  input  logic               enq_ds_rdy,
  input  logic               enq_dt_rdy,
  input  logic [VAL_W-1:0]   enq_ds_val,
  input  logic [VAL_W-1:0]   enq_dt_val,
  input  logic [TAG_W-1:0]   enq_ds_tag,
  input  logic [TAG_W-1:0]   enq_dt_tag,
  input  logic [TAG_W-1:0]   wb0_addr,
  input  logic [VAL_W-1:0]   wb0_val,
  input  logic [TAG_W-1:0]   wb1_addr,
  input  logic [VAL_W-1:0]   wb1_val,
  input  logic [6:0]         busy,
  input  logic               flush,
  output logic [PC_W-1:0]    pc,
  output logic [OPE_W-1:0]   ope,
  output logic [VAL_W-1:0]   ds_val,
  output logic [VAL_W-1:0]   dt_val,
  output logic [DD_W-1:0]    dd,
  output logic [IMM_W-1:0]   imm,
  output logic [OPR_W-1:0]   opr,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [COUNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [COUNT_W-1:0] count_r;
  logic               enq_ready_r;
  instr_t             out_instr_r;
  logic [VAL_W-1:0]   out_ds_val_r;
  logic [VAL_W-1:0]   out_dt_val_r;

  logic               valid_s  [DEPTH];
  instr_t             instr_s  [DEPTH];
  logic               ds_rdy_s [DEPTH];
  logic [VAL_W-1:0]   ds_val_s [DEPTH];
  logic               dt_rdy_s [DEPTH];
  logic [VAL_W-1:0]   dt_val_s [DEPTH];

  instr_t             enq_instr_s;
  opnd_t              enq_ds_s;
  opnd_t              enq_dt_s;
  logic               do_enq_s;
  logic               do_issue_s;
  logic [COUNT_W-1:0] count_next_s;

  // Enqueue/issue decisions use only stored ready flags, so a wakeup never bypasses into issue.
  always_comb begin
    enq_instr_s  = '{pc: enq_pc, ope: enq_ope, dd: enq_dd, imm: enq_imm, opr: enq_opr, ctrl: enq_ctrl};
    enq_ds_s     = '{rdy: enq_ds_rdy, tag: enq_ds_tag, val: enq_ds_val};
    enq_dt_s     = '{rdy: enq_dt_rdy, tag: enq_dt_tag, val: enq_dt_val};
    do_enq_s     = enq_valid && enq_ready_r && !flush;
    do_issue_s   = valid_s[head_r] && ds_rdy_s[head_r] && dt_rdy_s[head_r] &&
                   (busy == 7'b0000000) && !flush;
    count_next_s = count_r;
    case ({do_enq_s, do_issue_s})
      2'b10:   count_next_s = count_r + 4'd1;
      2'b01:   count_next_s = count_r - 4'd1;
      default: count_next_s = count_r;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    unit1_iq_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .load      (do_enq_s && (tail_r == PTR_W'(i))),
      .pop       (do_issue_s && (head_r == PTR_W'(i))),
      .enq_instr (enq_instr_s),
      .enq_ds    (enq_ds_s),
      .enq_dt    (enq_dt_s),
      .wb0_addr  (wb0_addr),
      .wb0_val   (wb0_val),
      .wb1_addr  (wb1_addr),
      .wb1_val   (wb1_val),
      .valid     (valid_s[i]),
      .instr     (instr_s[i]),
      .ds_rdy    (ds_rdy_s[i]),
      .ds_val    (ds_val_s[i]),
      .dt_rdy    (dt_rdy_s[i]),
      .dt_val    (dt_val_s[i])
    );
  end

  // Pointers, occupancy, registered ready and the issue slot (bubble when nothing issues).
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r       <= '0;
      tail_r       <= '0;
      count_r      <= 4'd0;
      enq_ready_r  <= 1'b0;
      out_instr_r  <= '0;
      out_ds_val_r <= 32'd0;
      out_dt_val_r <= 32'd0;
    end else if (flush) begin
      head_r       <= '0;
      tail_r       <= '0;
      count_r      <= 4'd0;
      enq_ready_r  <= 1'b1;
      out_instr_r  <= '0;
      out_ds_val_r <= 32'd0;
      out_dt_val_r <= 32'd0;
    end else begin
      if (do_enq_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      count_r     <= count_next_s;
      enq_ready_r <= (count_next_s < COUNT_W'(DEPTH));
      if (do_issue_s) begin
        head_r       <= head_r + PTR_W'(1);
        out_instr_r  <= instr_s[head_r];
        out_ds_val_r <= ds_val_s[head_r];
        out_dt_val_r <= dt_val_s[head_r];
      end else begin
        out_instr_r  <= '0;
        out_ds_val_r <= 32'd0;
        out_dt_val_r <= 32'd0;
      end
    end
  end

  assign enq_ready = enq_ready_r;
  assign count     = count_r;
  assign pc        = out_instr_r.pc;
  assign ope       = out_instr_r.ope;
  assign dd        = out_instr_r.dd;
  assign imm       = out_instr_r.imm;
  assign opr       = out_instr_r.opr;
  assign ctrl      = out_instr_r.ctrl;
  assign ds_val    = out_ds_val_r;
  assign dt_val    = out_dt_val_r;

endmodule

// File: tb/tb_unit1_issue_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_unit1_issue_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, enq_valid, enq_ready, flush;
  logic [13:0] enq_pc, pc;
  logic [5:0]  enq_ope, enq_dd, ope, dd;
  logic [15:0] enq_imm, imm;
  logic [4:0]  enq_opr, opr;
  logic [3:0]  enq_ctrl, ctrl, count;
  logic        enq_ds_rdy, enq_dt_rdy;
  logic [31:0] enq_ds_val, enq_dt_val, wb0_val, wb1_val, ds_val, dt_val;
  logic [5:0]  enq_ds_tag, enq_dt_tag, wb0_addr, wb1_addr;
  logic [6:0]  busy;

  always #5 clk = ~clk;

  unit1_issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_ope(enq_ope), .enq_dd(enq_dd), .enq_imm(enq_imm),
    .enq_opr(enq_opr), .enq_ctrl(enq_ctrl), .enq_ds_rdy(enq_ds_rdy), .enq_dt_rdy(enq_dt_rdy),
    .enq_ds_val(enq_ds_val), .enq_dt_val(enq_dt_val), .enq_ds_tag(enq_ds_tag), .enq_dt_tag(enq_dt_tag),
    .wb0_addr(wb0_addr), .wb0_val(wb0_val), .wb1_addr(wb1_addr), .wb1_val(wb1_val),
    .busy(busy), .flush(flush), .pc(pc), .ope(ope), .ds_val(ds_val), .dt_val(dt_val),
    .dd(dd), .imm(imm), .opr(opr), .ctrl(ctrl), .count(count)
  );

  typedef struct {
    logic [13:0] pc;
    logic [5:0]  ope;
    logic [5:0]  dd;
    logic [15:0] imm;
    logic [4:0]  opr;
    logic [3:0]  ctrl;
    logic        ds_rdy;
    logic [31:0] ds_val;
    logic [5:0]  ds_tag;
    logic        dt_rdy;
    logic [31:0] dt_val;
    logic [5:0]  dt_tag;
  } ment_t;

  ment_t m_q[$];
  ment_t m_out;
  logic  m_ready = 1'b0;
  bit    started = 1'b0;
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ment_t zero_ent();
    ment_t r;
    r.pc = 14'd0; r.ope = 6'd0; r.dd = 6'd0; r.imm = 16'd0; r.opr = 5'd0; r.ctrl = 4'd0;
    r.ds_rdy = 1'b0; r.ds_val = 32'd0; r.ds_tag = 6'd0;
    r.dt_rdy = 1'b0; r.dt_val = 32'd0; r.dt_tag = 6'd0;
    return r;
  endfunction

  function automatic ment_t wake(input ment_t e);
    ment_t r;
    r = e;
    if (!r.ds_rdy && wb0_addr != 6'd0 && wb0_addr == r.ds_tag) begin
      r.ds_rdy = 1'b1; r.ds_val = wb0_val;
    end else if (!r.ds_rdy && wb1_addr != 6'd0 && wb1_addr == r.ds_tag) begin
      r.ds_rdy = 1'b1; r.ds_val = wb1_val;
    end
    if (!r.dt_rdy && wb0_addr != 6'd0 && wb0_addr == r.dt_tag) begin
      r.dt_rdy = 1'b1; r.dt_val = wb0_val;
    end else if (!r.dt_rdy && wb1_addr != 6'd0 && wb1_addr == r.dt_tag) begin
      r.dt_rdy = 1'b1; r.dt_val = wb1_val;
    end
    return r;
  endfunction

  // Reference model update at each edge, then compare DUT outputs just after it.
  always @(posedge clk) begin
    ment_t e;
    bit    iss;
    if (rst) begin
      m_q.delete();
      m_ready = 1'b0;
      m_out   = zero_ent();
      started = 1'b1;
    end else if (flush) begin
      m_q.delete();
      m_ready = 1'b1;
      m_out   = zero_ent();
    end else begin
      iss = (m_q.size() > 0) && m_q[0].ds_rdy && m_q[0].dt_rdy && (busy == 7'd0);
      for (int i = 0; i < m_q.size(); i++) m_q[i] = wake(m_q[i]);
      if (iss) m_out = m_q.pop_front();
      else m_out = zero_ent();
      if (enq_valid && m_ready) begin
        e = zero_ent();
        e.pc = enq_pc; e.ope = enq_ope; e.dd = enq_dd; e.imm = enq_imm; e.opr = enq_opr; e.ctrl = enq_ctrl;
        e.ds_rdy = enq_ds_rdy; e.ds_val = enq_ds_val; e.ds_tag = enq_ds_tag;
        e.dt_rdy = enq_dt_rdy; e.dt_val = enq_dt_val; e.dt_tag = enq_dt_tag;
        m_q.push_back(wake(e));
      end
      m_ready = (m_q.size() < DEPTH);
    end
    #1;
    if (started) begin
      chk("count", count, m_q.size());
      chk("enq_ready", enq_ready, m_ready);
      chk("pc", pc, m_out.pc);
      chk("ope", ope, m_out.ope);
      chk("dd", dd, m_out.dd);
      chk("imm", imm, m_out.imm);
      chk("opr", opr, m_out.opr);
      chk("ctrl", ctrl, m_out.ctrl);
      chk("ds_val", ds_val, m_out.ds_val);
      chk("dt_val", dt_val, m_out.dt_val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; busy = 7'd0;
    wb0_addr = 6'd0; wb0_val = 32'd0; wb1_addr = 6'd0; wb1_val = 32'd0;
  endtask

  task automatic enq(input logic [5:0] o, input logic [13:0] p,
                     input logic sr, input logic [31:0] sv, input logic [5:0] st,
                     input logic tr, input logic [31:0] tv, input logic [5:0] tt);
    enq_valid = 1'b1; enq_pc = p; enq_ope = o; enq_dd = p[5:0]; enq_imm = {2'b00, p};
    enq_opr = p[4:0]; enq_ctrl = p[3:0];
    enq_ds_rdy = sr; enq_ds_val = sv; enq_ds_tag = st;
    enq_dt_rdy = tr; enq_dt_val = tv; enq_dt_tag = tt;
  endtask

  initial begin
    idle();
    enq(6'd0, 14'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0);
    enq_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_count", count, 32'd0);
    chk("rst_ready", enq_ready, 32'd0);
    chk("rst_ope", ope, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst", enq_ready, 32'd1);

    // Basic ADD: enqueue at edge 0, issue at edge 1, bubble at edge 2.
    enq(6'b001100, 14'h010, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0);
    tick(); idle();
    chk("add_count", count, 32'd1);
    tick();
    chk("add_ope", ope, 32'h0c);
    chk("add_ds", ds_val, 32'd5);
    chk("add_dt", dt_val, 32'd7);
    tick();
    chk("add_bubble", ope, 32'd0);

    // Wakeup via wb0 at edge 2, issue at edge 3 only.
    enq(6'b000101, 14'h020, 1'b0, 32'd0, 6'd3, 1'b1, 32'd9, 6'd0);
    tick(); idle();
    tick();
    chk("wake_early", ope, 32'd0);
    wb0_addr = 6'd3; wb0_val = 32'h1234;
    tick(); idle();
    chk("wake_nobypass", ope, 32'd0);
    tick();
    chk("wake_ope", ope, 32'h05);
    chk("wake_ds", ds_val, 32'h1234);

    // Fill with blocked head, 5th offer ignored, wake head then drain.
    enq(6'b000110, 14'h030, 1'b0, 32'd0, 6'd10, 1'b1, 32'd1, 6'd0);
    tick();
    for (int k = 1; k < 4; k++) begin
      enq(6'b000111, 14'(48 + k), 1'b1, 32'(k), 6'd0, 1'b1, 32'(k + 1), 6'd0);
      tick();
    end
    chk("full_count", count, 32'd4);
    chk("full_ready", enq_ready, 32'd0);
    enq(6'b001000, 14'h03f, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0);
    tick(); idle();
    chk("fifth_ignored", count, 32'd4);
    wb0_addr = 6'd10; wb0_val = 32'hcafe;
    tick(); idle();
    tick();
    chk("full_pop_ope", ope, 32'h06);
    chk("full_pop_ds", ds_val, 32'hcafe);
    chk("full_pop_count", count, 32'd3);
    chk("full_pop_ready", enq_ready, 32'd1);
    repeat (6) tick();

    // Flush with 3 entries and a concurrent enqueue.
    enq(6'b001001, 14'h040, 1'b0, 32'd0, 6'd20, 1'b1, 32'd0, 6'd0);
    tick();
    enq(6'b001001, 14'h041, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0);
    tick();
    chk("young_waits", ope, 32'd0);
    enq(6'b001001, 14'h042, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2, 6'd0);
    tick();
    chk("preflush_count", count, 32'd3);
    enq(6'b001010, 14'h043, 1'b1, 32'd3, 6'd0, 1'b1, 32'd3, 6'd0);
    flush = 1'b1;
    tick(); idle();
    chk("flush_count", count, 32'd0);
    chk("flush_ope", ope, 32'd0);
    chk("flush_ready", enq_ready, 32'd1);
    wb0_addr = 6'd20; wb0_val = 32'd1;
    tick(); idle();
    repeat (4) tick();
    chk("flush_dropped", ope, 32'd0);

    // Busy stall for 3 edges, then issue.
    enq(6'b001011, 14'h050, 1'b1, 32'h11, 6'd0, 1'b1, 32'h22, 6'd0);
    tick(); idle();
    busy = 7'b0000100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_bubble", ope, 32'd0);
    end
    busy = 7'd0;
    tick();
    chk("busy_issue_ope", ope, 32'h0b);
    chk("busy_issue_ds", ds_val, 32'h11);

    // Both buses match the same tag: wb0 wins.
    enq(6'b001101, 14'h060, 1'b0, 32'd0, 6'd7, 1'b1, 32'h5, 6'd0);
    tick(); idle();
    wb0_addr = 6'd7; wb0_val = 32'haaaa; wb1_addr = 6'd7; wb1_val = 32'hbbbb;
    tick(); idle();
    tick();
    chk("wb0_wins", ds_val, 32'haaaa);

    // Wakeup applied on the enqueue edge via wb1.
    enq(6'b001110, 14'h070, 1'b1, 32'h3, 6'd0, 1'b0, 32'd0, 6'd12);
    wb1_addr = 6'd12; wb1_val = 32'h7777;
    tick(); idle();
    tick();
    chk("enq_wake_ope", ope, 32'h0e);
    chk("enq_wake_dt", dt_val, 32'h7777);

    // Reset mid-stream with a wakeup pending.
    enq(6'b001111, 14'h080, 1'b0, 32'd0, 6'd25, 1'b1, 32'd0, 6'd0);
    tick();
    enq(6'b001111, 14'h081, 1'b1, 32'd8, 6'd0, 1'b1, 32'd8, 6'd0);
    tick(); idle();
    rst = 1'b1; wb0_addr = 6'd25; wb0_val = 32'd5;
    tick(); idle();
    chk("midrst_count", count, 32'd0);
    chk("midrst_ready", enq_ready, 32'd0);
    chk("midrst_pc", pc, 32'd0);
    tick();
    chk("midrst_ready_back", enq_ready, 32'd1);
    wb0_addr = 6'd25;
    repeat (3) tick();
    chk("midrst_no_stale", ope, 32'd0);
    idle();

    // Streaming: enqueue and issue on the same edges, occupancy stays 1.
    for (int k = 0; k < 6; k++) begin
      enq(6'(16 + k), 14'(256 + k), 1'b1, 32'(100 + k), 6'd0, 1'b1, 32'(200 + k), 6'd0);
      tick();
      chk("stream_count", count, 32'd1);
    end
    idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/unit1_issue_fifo.md
UNIT1_ISSUE_FIFO -- requirements
Module: unit1_issue_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 enq_valid  input  1  decode offers an instruction this cycle.
REQ-005 enq_ready  output  1  queue accepts; registered, 1 when occupancy < DEPTH.
REQ-006 enq_pc[13:0], enq_ope[5:0], enq_dd[5:0], enq_imm[15:0], enq_opr[4:0], enq_ctrl[3:0]  input  various  instruction fields (ctrl[0] = predicted taken).
REQ-007 enq_ds_rdy, enq_dt_rdy  input  1 each  source operand value already valid.
REQ-008 enq_ds_val, enq_dt_val  input  32 each  operand value when rdy, else don't-care.
REQ-009 enq_ds_tag, enq_dt_tag  input  6 each  producing register address when not rdy.
REQ-010 wb0_addr[5:0], wb0_val[31:0]  input  ALU result bus; addr 0 = no write.
REQ-011 wb1_addr[5:0], wb1_val[31:0]  input  FPU result bus; addr 0 = no write.
REQ-012 busy[6:0]  input  execution unit busy vector; any bit set stalls issue.
REQ-013 flush  input  1  branch/jump redirect (b_is_hazard of the execute stage).
REQ-014 pc[13:0], ope[5:0], ds_val[31:0], dt_val[31:0], dd[5:0], imm[15:0], opr[4:0], ctrl[3:0]  output  registered issue slot to the execute stage.
REQ-015 count[3:0]  output  current occupancy.

Function
REQ-016 Queue SHALL be in-order circular buffer, head/tail pointers wrapping modulo DEPTH.
REQ-017 Enqueue SHALL occur at an edge where enq_valid && enq_ready && !flush; entry becomes issue-eligible from the next edge.
REQ-018 Wakeup: for each stored entry with operand not ready, if wb0_addr or wb1_addr != 0 and equals its tag, operand SHALL latch that bus value and set ready; wb0 wins if both match.
REQ-019 Wakeup SHALL also apply to the entry being enqueued in the same cycle (tag match captures bus value at enqueue).
REQ-020 Issue SHALL occur at an edge where head valid, both head operands ready (stored flags), busy == 0 and !flush; head fields load into output regs, head pops.
REQ-021 Operand woken at edge k SHALL not issue before edge k+1 (no bypass into issue path).
REQ-022 At every edge without issue, output regs SHALL load a bubble: ope=0, dd=0, all other outputs 0.
REQ-023 Simultaneous enqueue and issue SHALL be allowed; count unchanged; enqueue into a full queue SHALL never occur even if issue pops the same cycle.
REQ-024 Flush SHALL invalidate all entries, reset pointers and count to 0, drop any concurrent enqueue, and load a bubble into output regs at the same edge.
REQ-025 Only the head may issue; a ready younger entry SHALL wait behind a non-ready head.
REQ-026 count SHALL equal accepted enqueues minus issues since last reset/flush, range 0..DEPTH.

Reset
REQ-027 While rst is sampled high: all entries invalid, pointers 0, count 0, enq_ready 0 for that cycle then 1, all issue outputs 0.
REQ-028 rst SHALL take priority over flush, enqueue, wakeup and issue at the same edge.

Structure
REQ-029 Opcode constants (NOP=6'b000000) and entry-field widths SHALL live in the shared core package used by decode and execute.
REQ-030 One sub-module, unit1_iq_entry, SHALL hold one entry's fields plus per-operand tag-compare/wakeup logic; instantiated DEPTH times.

Verification
REQ-031 Enqueue ADD, both rdy, ds=5, dt=7, busy=0 at edge 0 -> ope=6'b001100, ds_val=5, dt_val=7 on outputs after edge 1; bubble after edge 2.
REQ-032 Enqueue entry ds_tag=3 not ready; wb0_addr=3, wb0_val=0x1234 at edge 2 -> issues at edge 3 with ds_val=0x1234, not earlier.
REQ-033 Enqueue 4 entries with head not ready -> enq_ready=0, count=4; 5th enq_valid ignored; wake head -> pops, enq_ready=1 next cycle.
REQ-034 Queue holds 3 entries, flush with concurrent enq_valid -> count=0, outputs bubble, dropped entry never issues.
REQ-035 Head ready, busy=7'b0000100 for 3 cycles -> 3 bubbles, issue at first edge with busy=0; wb0 and wb1 both match same tag -> wb0_val captured.
REQ-036 Assert rst mid-stream with 2 entries and a wakeup pending -> all outputs 0, count 0 next cycle, no stale issue afterwards.
